bomb_explode_gen: RTL and testbench
===================================

// Module: bomb_explode_gen
// PURPOSE
// - Produces the 256-bit explosion map consumed by the game-over detector, plus a map of armed bombs for the renderer.
// - Players drop bombs on a 16x16 grid. A bomb's fuse counts down in frame ticks, then it blasts a clipped cross for a fixed time.
// - Sits between the player/input logic and the game-over detector; o_explode drives that block's i_explode.
// PARAMETERS
// - NUM_SLOTS    4    concurrent bombs tracked (1..8)
// - FUSE_TICKS   120  ticks from placement to blast (1..255)
// - BLAST_TICKS  30   ticks the blast stays active (1..255)
// - RANGE        2    blast arm length in cells from the centre (0..15)
// PORTS
// - clk        in   1    system clock
// - reset      in   1    asynchronous, active-high reset
// - i_tick     in   1    one-cycle frame strobe (60 Hz); timers advance only on it
// - i_halt     in   1    freeze all timers (tie to game-over state != NONE); placements ignored
// - p1_place   in   1    P1 bomb request, one-cycle pulse
// - p1_cor     in   8    P1 cell {row[7:4], col[3:0]}
// - p2_place   in   1    P2 bomb request
// - p2_cor     in   8    P2 cell
// - o_bomb     out  256  bit[cor]=1 where an ARMED bomb sits
// - o_explode  out  256  bit[cor]=1 where any BLAST covers the cell
// - o_full     out  1    no IDLE slot free
// BEHAVIOUR
// - Clock and reset: one clock, clk. Reset is asynchronous and active-high. On reset every slot goes IDLE with cor=0 and timer=0, so o_bomb=0, o_explode=0 and o_full=0.
// - Per-slot FSM: IDLE -> ARMED -> BLAST -> IDLE. Each slot holds an 8-bit cor and an 8-bit timer.
// - Accepting a request:
//   - On the edge that samples place=1, with i_halt=0, a free slot exists and no ARMED slot already has that cor:
//   - the lowest-index IDLE slot takes cor, enters ARMED, and its timer is loaded with FUSE_TICKS.
// - Simultaneous P1 and P2 requests:
//   - P1 is allocated first (lowest free slot); P2 gets the next free slot.
//   - Same cor from both in one cycle: P1 accepted, P2 dropped.
//   - Only one slot free: P1 accepted, P2 dropped.
// - Dropped requests: a request with no free slot, a duplicate cor, or i_halt=1 is dropped silently. Nothing is queued.
// - ARMED timing:
//   - On each cycle with i_tick=1 and i_halt=0, timer decrements by 1.
//   - When a tick would take timer from 1 to 0, the slot instead enters BLAST with timer=BLAST_TICKS.
// - BLAST timing: same decrement rule. When a tick would take timer from 1 to 0, the slot enters IDLE.
// - Output decode: o_bomb, o_explode and o_full are decoded combinationally from slot registers. An accepted placement shows in o_bomb right after its edge; blast cells show in o_explode right after the entering edge. There is no extra latency.
// - Blast pattern:
//   - Centre cell, plus cells up to RANGE along row and column in all four directions.
//   - Clipped at the grid edges: row/col below 0 or above 15 is omitted, with no wrap-around (col 15 +1 does not reach col 0 of the next row).
// - Overlaps: overlapping blasts OR together. A cell may be both ARMED (o_bomb) and covered by another blast.
// - i_halt=1: timers and FSMs hold; outputs stay static.
// - Placement on a blasting cell is allowed: the new bomb is armed and the blast is unaffected.
// CONFIGURATION
// - Macro: BOMB_CHAIN_REACTION_EN
// - Defined: any ARMED slot whose cor bit is set in the current o_explode goes to BLAST (timer=BLAST_TICKS) on the next clk edge. This is independent of i_tick and suppressed by i_halt. Chained bombs form a per-cycle cascade, one hop per clock.
// - Undefined: ARMED bombs ignore o_explode and only their own fuse triggers the blast.
// TESTING (FUSE_TICKS=3, BLAST_TICKS=2, RANGE=2 for all)
// - Reset mid-blast, with a slot in BLAST at 0x55 -> o_explode=0, o_bomb=0, o_full=0 immediately. The slot is reusable on the first edge after reset deasserts.
// - P1 places at 0x00, then 3 ticks:
//   - o_bomb[0x00]=1 until the 3rd tick.
//   - Then o_explode has exactly bits 0x00, 0x01, 0x02, 0x10, 0x20, with no wrap to 0x0F/0xF0.
//   - After 2 more ticks everything is 0.
// - Same-cycle P1 and P2 at 0x77 -> one slot used, o_bomb has only bit 0x77. Same-cycle P1 0x11 and P2 0x22 -> slots 0 and 1, both bits set.
// - Fill NUM_SLOTS=4 slots -> o_full=1. A 5th request at 0x99 is dropped and o_bomb[0x99] stays 0.
// - i_halt=1 for 10 ticks with armed bombs -> no state change. The fuse resumes with its remaining count.
// - Bombs at 0x33 (tick 0) and 0x35 (tick 2):
//   - With BOMB_CHAIN_REACTION_EN: 0x35 blasts one clk after 0x33 blasts.
//   - Without it: 0x35 blasts 2 ticks later.

Source files
------------

// File: rtl/bomb_explode_gen_if.sv
// Player-side to bomb-generator bundle: placement requests, frame strobe, halt, and the two cell maps.
// Latency: none; a plain bundle of wires.
// Backpressure: none; requests are fire-and-forget pulses, o_full only reports slot occupancy.
interface bomb_explode_gen_if;
  logic         i_tick;
  logic         i_halt;
  logic         p1_place;
  logic [7:0]   p1_cor;
  logic         p2_place;
  logic [7:0]   p2_cor;
  logic [255:0] o_bomb;
  logic [255:0] o_explode;
  logic         o_full;

  // Player/input logic side
  modport master (
    output i_tick, i_halt, p1_place, p1_cor, p2_place, p2_cor,
    input  o_bomb, o_explode, o_full
  );

  // Bomb generator side
  modport slave (
    input  i_tick, i_halt, p1_place, p1_cor, p2_place, p2_cor,
    output o_bomb, o_explode, o_full
  );
endinterface

// File: rtl/bomb_explode_gen.sv
// Tracks up to NUM_SLOTS bombs (IDLE->ARMED->BLAST->IDLE) and decodes 16x16 armed/blast maps.
// Latency: placements and state changes are visible on the outputs right after the clocking edge.
// Backpressure: none; requests without a free slot, duplicates or while halted are silently dropped.
// Optional feature: define BOMB_CHAIN_REACTION_EN to let blasts detonate armed bombs they cover.
module bomb_explode_gen #(
  parameter int NUM_SLOTS   = 4,
  parameter int FUSE_TICKS  = 120,
  parameter int BLAST_TICKS = 30,
  parameter int RANGE       = 2
) (
  input logic               clk,
  input logic               reset,
  bomb_explode_gen_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_BLAST = 2'd2
  } state_t;

  localparam logic [7:0] LP_FUSE  = 8'(FUSE_TICKS);
  localparam logic [7:0] LP_BLAST = 8'(BLAST_TICKS);

  state_t       r_state [NUM_SLOTS];
  logic [7:0]   r_cor   [NUM_SLOTS];
  logic [7:0]   r_timer [NUM_SLOTS];

  state_t       w_state_nxt [NUM_SLOTS];
  logic [7:0]   w_cor_nxt   [NUM_SLOTS];
  logic [7:0]   w_timer_nxt [NUM_SLOTS];

  logic [NUM_SLOTS-1:0] w_idle;
  logic [NUM_SLOTS-1:0] w_chain;
  logic [NUM_SLOTS-1:0] w_p1_gnt;
  logic [NUM_SLOTS-1:0] w_p2_gnt;
  logic                 w_p1_dup;
  logic                 w_p2_dup;
  logic                 w_p1_ok;
  logic                 w_p2_ok;
  logic                 w_p1_done;
  logic                 w_p2_done;
  logic [255:0]         w_bomb;
  logic [255:0]         w_explode;
  int                   w_rr;
  int                   w_cc;

  // Per-slot status: which slots are free and whether a request duplicates an armed bomb
  always_comb begin
    w_idle   = '0;
    w_p1_dup = 1'b0;
    w_p2_dup = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      w_idle[s] = (r_state[s] == S_IDLE);
      if (r_state[s] == S_ARMED && r_cor[s] == bus.p1_cor) w_p1_dup = 1'b1;
      if (r_state[s] == S_ARMED && r_cor[s] == bus.p2_cor) w_p2_dup = 1'b1;
    end
  end

  // Slot allocation: P1 takes the lowest free slot, P2 the next one; P2 loses a same-cell tie
  always_comb begin
    w_p1_ok   = bus.p1_place & ~bus.i_halt & ~w_p1_dup;
    w_p2_ok   = bus.p2_place & ~bus.i_halt & ~w_p2_dup &
                ~(bus.p1_place & (bus.p1_cor == bus.p2_cor));
    w_p1_gnt  = '0;
    w_p2_gnt  = '0;
    w_p1_done = ~w_p1_ok;
    w_p2_done = ~w_p2_ok;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (w_idle[s]) begin
        if (!w_p1_done) begin
          w_p1_gnt[s] = 1'b1;
          w_p1_done   = 1'b1;
        end else if (!w_p2_done) begin
          w_p2_gnt[s] = 1'b1;
          w_p2_done   = 1'b1;
        end
      end
    end
  end

  // Map decode: armed cells, and a clipped cross of RANGE cells around every blasting slot
  always_comb begin
    w_bomb    = '0;
    w_explode = '0;
    w_rr      = 0;
    w_cc      = 0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (r_state[s] == S_ARMED) w_bomb[r_cor[s]] = 1'b1;
      if (r_state[s] == S_BLAST) begin
        for (int d = -RANGE; d <= RANGE; d++) begin
          w_rr = int'(r_cor[s][7:4]) + d;
          w_cc = int'(r_cor[s][3:0]) + d;
          // Row and column are clipped independently, so no arm wraps into a neighbouring row
          if (w_rr >= 0 && w_rr <= 15) w_explode[{w_rr[3:0], r_cor[s][3:0]}] = 1'b1;
          if (w_cc >= 0 && w_cc <= 15) w_explode[{r_cor[s][7:4], w_cc[3:0]}] = 1'b1;
        end
      end
    end
  end

  // Chain trigger: an armed bomb sitting under a current blast detonates on the next edge
  always_comb begin
    w_chain = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
`ifdef BOMB_CHAIN_REACTION_EN
      w_chain[s] = (r_state[s] == S_ARMED) && w_explode[r_cor[s]];
`else
      w_chain[s] = 1'b0;
`endif
    end
  end

  // Per-slot next state: placement, fuse countdown, blast countdown; everything frozen while halted
  always_comb begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      w_state_nxt[s] = r_state[s];
      w_cor_nxt[s]   = r_cor[s];
      w_timer_nxt[s] = r_timer[s];
      if (!bus.i_halt) begin
        case (r_state[s])
          S_IDLE: begin
            if (w_p1_gnt[s]) begin
              w_state_nxt[s] = S_ARMED;
              w_cor_nxt[s]   = bus.p1_cor;
              w_timer_nxt[s] = LP_FUSE;
            end else if (w_p2_gnt[s]) begin
              w_state_nxt[s] = S_ARMED;
              w_cor_nxt[s]   = bus.p2_cor;
              w_timer_nxt[s] = LP_FUSE;
            end
          end
          S_ARMED: begin
            if (w_chain[s] || (bus.i_tick && r_timer[s] == 8'd1)) begin
              w_state_nxt[s] = S_BLAST;
              w_timer_nxt[s] = LP_BLAST;
            end else if (bus.i_tick) begin
              w_timer_nxt[s] = r_timer[s] - 8'd1;
            end
          end
          S_BLAST: begin
            if (bus.i_tick && r_timer[s] == 8'd1) begin
              w_state_nxt[s] = S_IDLE;
              w_timer_nxt[s] = 8'd0;
            end else if (bus.i_tick) begin
              w_timer_nxt[s] = r_timer[s] - 8'd1;
            end
          end
          default: begin
            w_state_nxt[s] = S_IDLE;
            w_timer_nxt[s] = 8'd0;
          end
        endcase
      end
    end
  end

  // Slot registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        r_state[s] <= S_IDLE;
        r_cor[s]   <= 8'd0;
        r_timer[s] <= 8'd0;
      end
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        r_state[s] <= w_state_nxt[s];
        r_cor[s]   <= w_cor_nxt[s];
        r_timer[s] <= w_timer_nxt[s];
      end
    end
  end

  assign bus.o_bomb    = w_bomb;
  assign bus.o_explode = w_explode;
  assign bus.o_full    = ~|w_idle;

endmodule

// File: tb/tb_bomb_explode_gen.sv
// Self-checking bench for bomb_explode_gen with FUSE_TICKS=3, BLAST_TICKS=2, RANGE=2.
// Latency: outputs are sampled 1 ns after each rising edge.
// Backpressure: none; placement pulses are driven for exactly one cycle.
module tb_bomb_explode_gen;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bomb_explode_gen_if bus ();

  bomb_explode_gen #(
    .NUM_SLOTS  (4),
    .FUSE_TICKS (3),
    .BLAST_TICKS(2),
    .RANGE      (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic       tick;
    logic       halt;
    logic       p1;
    logic [7:0] c1;
    logic       p2;
    logic [7:0] c2;
    logic [7:0] probe;
    int         bn;
    int         en;
    logic       full;
    logic       pb;
    logic       pe;
    logic       chk_map;
  } vec_t;

  vec_t         tbl[$];
  logic [255:0] map_a;

  function automatic vec_t mkv(input logic tick, input logic halt,
                               input logic p1, input logic [7:0] c1,
                               input logic p2, input logic [7:0] c2,
                               input logic [7:0] probe, input int bn, input int en,
                               input logic full, input logic pb, input logic pe,
                               input logic chk_map);
    vec_t v;
    v.tick = tick; v.halt = halt; v.p1 = p1; v.c1 = c1; v.p2 = p2; v.c2 = c2;
    v.probe = probe; v.bn = bn; v.en = en; v.full = full; v.pb = pb; v.pe = pe;
    v.chk_map = chk_map;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, and return 1 ns after the edge with inputs cleared
  task automatic cyc(input logic tick, input logic halt, input logic p1, input logic [7:0] c1,
                     input logic p2, input logic [7:0] c2);
    bus.i_tick   = tick;
    bus.i_halt   = halt;
    bus.p1_place = p1;
    bus.p1_cor   = c1;
    bus.p2_place = p2;
    bus.p2_cor   = c2;
    @(posedge clk);
    #1;
    bus.i_tick   = 1'b0;
    bus.i_halt   = 1'b0;
    bus.p1_place = 1'b0;
    bus.p2_place = 1'b0;
  endtask

  task automatic chk_counts(input string nm, input int bn, input int en, input logic full);
    chk({nm, "_bomb_cnt"}, $countones(bus.o_bomb), bn);
    chk({nm, "_explode_cnt"}, $countones(bus.o_explode), en);
    chk({nm, "_full"}, int'(bus.o_full), int'(full));
  endtask

  initial begin
    reset        = 1'b1;
    bus.i_tick   = 1'b0;
    bus.i_halt   = 1'b0;
    bus.p1_place = 1'b0;
    bus.p1_cor   = 8'h00;
    bus.p2_place = 1'b0;
    bus.p2_cor   = 8'h00;

    map_a = '0;
    map_a[8'h00] = 1'b1;
    map_a[8'h01] = 1'b1;
    map_a[8'h02] = 1'b1;
    map_a[8'h10] = 1'b1;
    map_a[8'h20] = 1'b1;

    //                 tick halt p1 c1     p2 c2     probe  bn en full pb pe map
    tbl.push_back(mkv(0, 0, 1, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 1, 0, 0)); // P1 at corner
    tbl.push_back(mkv(1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 1, 0, 0)); // tick 1
    tbl.push_back(mkv(1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 1, 0, 0)); // tick 2
    tbl.push_back(mkv(1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 5, 0, 0, 1, 1)); // tick 3: clipped blast
    tbl.push_back(mkv(0, 0, 0, 8'h00, 0, 8'h00, 8'h02, 0, 5, 0, 0, 1, 0)); // no tick: holds
    tbl.push_back(mkv(1, 0, 0, 8'h00, 0, 8'h00, 8'h20, 0, 5, 0, 0, 1, 0)); // blast tick 1
    tbl.push_back(mkv(1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)); // blast over
    tbl.push_back(mkv(0, 0, 1, 8'h77, 1, 8'h77, 8'h77, 1, 0, 0, 1, 0, 0)); // same cell both
    tbl.push_back(mkv(0, 0, 1, 8'h11, 1, 8'h22, 8'h11, 3, 0, 0, 1, 0, 0)); // two cells both
    tbl.push_back(mkv(0, 0, 1, 8'h77, 1, 8'h44, 8'h44, 4, 0, 1, 1, 0, 0)); // P1 dup, P2 ok
    tbl.push_back(mkv(0, 0, 1, 8'h99, 1, 8'h55, 8'h99, 4, 0, 1, 0, 0, 0)); // full: dropped
    tbl.push_back(mkv(1, 0, 0, 8'h00, 0, 8'h00, 8'h22, 4, 0, 1, 1, 0, 0)); // fuses to 2

    #22;
    chk_counts("reset", 0, 0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].tick, tbl[i].halt, tbl[i].p1, tbl[i].c1, tbl[i].p2, tbl[i].c2);
      chk_counts($sformatf("row%0d", i), tbl[i].bn, tbl[i].en, tbl[i].full);
      chk($sformatf("row%0d_probe_bomb", i), int'(bus.o_bomb[tbl[i].probe]), int'(tbl[i].pb));
      chk($sformatf("row%0d_probe_explode", i), int'(bus.o_explode[tbl[i].probe]), int'(tbl[i].pe));
      if (tbl[i].chk_map) begin
        checks++;
        if (bus.o_explode !== map_a) begin
          errors++;
          $display("FAIL row%0d_explode_map: got %h, expected %h", i, bus.o_explode, map_a);
        end
      end
    end

    // Halt for 10 ticks with four armed bombs; a placement attempt is ignored too
    for (int i = 0; i < 10; i++) cyc(1, 1, 1, 8'h66, 0, 8'h00);
    chk_counts("halt", 4, 0, 1'b1);
    chk("halt_place_66", int'(bus.o_bomb[8'h66]), 0);
    cyc(1, 0, 0, 8'h00, 0, 8'h00);
    chk_counts("resume_t1", 4, 0, 1'b1);
    cyc(1, 0, 0, 8'h00, 0, 8'h00);
    chk_counts("resume_blast", 0, 30, 1'b1);
    cyc(1, 0, 0, 8'h00, 0, 8'h00);
    cyc(1, 0, 0, 8'h00, 0, 8'h00);
    chk_counts("all_idle", 0, 0, 1'b0);

    // Blast at 0x55, place onto a blasting cell, then reset mid-blast
    cyc(0, 0, 1, 8'h55, 0, 8'h00);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 8'h00, 0, 8'h00);
    chk_counts("blast55", 0, 9, 1'b0);
    cyc(0, 0, 1, 8'h56, 0, 8'h00);
    chk("place_on_blast_bomb", int'(bus.o_bomb[8'h56]), 1);
    chk("place_on_blast_explode", int'(bus.o_explode[8'h56]), 1);
    chk("place_on_blast_cnt", $countones(bus.o_explode), 9);
    reset = 1'b1;
    #1;
    chk_counts("reset_mid_blast", 0, 0, 1'b0);
    #2;
    reset = 1'b0;
    cyc(0, 0, 1, 8'h55, 0, 8'h00);
    chk("reuse_after_reset", int'(bus.o_bomb[8'h55]), 1);
    chk_counts("reuse_after_reset", 1, 0, 1'b0);
    cyc(0, 1, 1, 8'h66, 0, 8'h00);
    chk("halt_drop_66", int'(bus.o_bomb[8'h66]), 0);

    // Neighbouring bombs 0x33 (tick 0) and 0x35 (tick 2)
    reset = 1'b1;
    #2;
    reset = 1'b0;
    cyc(0, 0, 1, 8'h33, 0, 8'h00);
    cyc(1, 0, 0, 8'h00, 0, 8'h00);
    cyc(1, 0, 0, 8'h00, 0, 8'h00);
    cyc(0, 0, 1, 8'h35, 0, 8'h00);
    cyc(1, 0, 0, 8'h00, 0, 8'h00);
    chk("b33_blast", int'(bus.o_explode[8'h33]), 1);
    chk("b35_armed", int'(bus.o_bomb[8'h35]), 1);
    chk("b35_covered", int'(bus.o_explode[8'h35]), 1);
    cyc(0, 0, 0, 8'h00, 0, 8'h00);
`ifdef BOMB_CHAIN_REACTION_EN
    chk("chain_b35_gone", int'(bus.o_bomb[8'h35]), 0);
    chk("chain_b35_blast", int'(bus.o_explode[8'h37]), 1);
`else
    chk("nochain_b35_armed", int'(bus.o_bomb[8'h35]), 1);
    chk("nochain_37_clear", int'(bus.o_explode[8'h37]), 0);
    cyc(1, 0, 0, 8'h00, 0, 8'h00);
    chk("nochain_b35_t1", int'(bus.o_bomb[8'h35]), 1);
    cyc(1, 0, 0, 8'h00, 0, 8'h00);
    chk("nochain_b35_blast", int'(bus.o_explode[8'h37]), 1);
    chk("nochain_b33_over", int'(bus.o_explode[8'h31]), 0);
    chk("nochain_b35_gone", int'(bus.o_bomb[8'h35]), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
